// File: rtl/slime_pkg.sv
// rtl/slime_pkg.sv - shared slime state encoding, sprite and screen geometry
package slime_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WALK_R  = 3'd1,
        ST_PAUSE_R = 3'd2,
        ST_WALK_L  = 3'd3,
        ST_PAUSE_L = 3'd4
    } state_e;

    localparam int SLIME_W  = 62;
    localparam int SLIME_H  = 36;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic logic facing_right(input state_e s);
        return !((s == ST_WALK_L) || (s == ST_PAUSE_L));
    endfunction

    function automatic logic is_walking(input state_e s);
        return (s == ST_WALK_R) || (s == ST_WALK_L);
    endfunction

endpackage

// File: rtl/slime_patrol_tick_gen.sv
// rtl/slime_patrol_tick_gen.sv - motion tick divider, counts only while enabled
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/slime_patrol.sv
// rtl/slime_patrol.sv - one slime walking between X_LEFT and X_RIGHT, pausing at each end
module slime_patrol
    import slime_pkg::*;
#(
    parameter logic [9:0] X_LEFT      = 10'd100,
    parameter logic [9:0] X_RIGHT     = 10'd400,
    parameter logic [8:0] Y_FLOOR     = 9'd300,
    parameter int         STEP_DIV    = 2_000_000,
    parameter logic [3:0] STEP_PX     = 4'd2,
    parameter logic [7:0] PAUSE_TICKS = 8'd25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       respawn,
    output logic [9:0] x_slim,
    output logic [8:0] y_slim,
    output logic       dir,
    output logic       moving,
    output logic [1:0] anim
);

    localparam logic [7:0]  PAUSE_LAST = PAUSE_TICKS - 8'd1;
    localparam logic [10:0] STEP_11    = {7'd0, STEP_PX};
    localparam logic [10:0] LEFT_LIM   = {1'b0, X_LEFT} + STEP_11;

    state_e     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic       dir_q, dir_d;
    logic       moving_q, moving_d;
    logic [1:0] anim_q, anim_d;
    logic [7:0] pause_q, pause_d;
    logic       tick;
    logic [10:0] sum_r;

    tick_gen #(
        .DIV (STEP_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .clr   (respawn),
        .tick  (tick)
    );

    // 11-bit sum so the right clamp can never be fooled by a 10-bit wrap
    assign sum_r = {1'b0, x_q} + STEP_11;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        anim_d  = anim_q;
        pause_d = pause_q;
        if (respawn) begin
            x_d     = X_LEFT;
            state_d = enable ? ST_WALK_R : ST_IDLE;
            anim_d  = 2'd0;
            pause_d = 8'd0;
        end else if (enable) begin
            case (state_q)
                ST_IDLE: state_d = ST_WALK_R;
                ST_WALK_R: begin
                    if (tick) begin
                        anim_d = anim_q + 2'd1;
                        if (sum_r >= {1'b0, X_RIGHT}) begin
                            x_d     = X_RIGHT;
                            state_d = ST_PAUSE_R;
                            pause_d = 8'd0;
                        end else begin
                            x_d = sum_r[9:0];
                        end
                    end
                end
                ST_WALK_L: begin
                    if (tick) begin
                        anim_d = anim_q + 2'd1;
                        if ({1'b0, x_q} <= LEFT_LIM) begin
                            x_d     = X_LEFT;
                            state_d = ST_PAUSE_L;
                            pause_d = 8'd0;
                        end else begin
                            x_d = x_q - {6'd0, STEP_PX};
                        end
                    end
                end
                ST_PAUSE_R, ST_PAUSE_L: begin
                    if (tick) begin
                        if (pause_q == PAUSE_LAST) begin
                            pause_d = 8'd0;
                            state_d = (state_q == ST_PAUSE_R) ? ST_WALK_L : ST_WALK_R;
                        end else begin
                            pause_d = pause_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        dir_d    = facing_right(state_d);
        moving_d = is_walking(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= X_LEFT;
            dir_q    <= 1'b1;
            moving_q <= 1'b0;
            anim_q   <= 2'd0;
            pause_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            anim_q   <= anim_d;
            pause_q  <= pause_d;
        end
    end

    assign x_slim = x_q;
    assign y_slim = Y_FLOOR;
    assign dir    = dir_q;
    assign moving = moving_q;
    assign anim   = anim_q;

endmodule

// File: tb/tb_slime_patrol.sv
// tb/tb_slime_patrol.sv - scoreboard bench: expected output changes queued, monitor pops on each change
module tb_slime_patrol;

    typedef struct {
        int          delta;
        logic [22:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, enable_a, respawn_a, enable_b, respawn_b;
    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic       dir_a, dir_b, mov_a, mov_b;
    logic [1:0] anim_a, anim_b;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [22:0] prev_a = '0, prev_b = '0;
    int last_a = 0, last_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slime_patrol #(
        .X_LEFT(10'd100), .X_RIGHT(10'd110), .Y_FLOOR(9'd300),
        .STEP_DIV(4), .STEP_PX(4'd2), .PAUSE_TICKS(8'd2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a), .respawn(respawn_a),
        .x_slim(x_a), .y_slim(y_a), .dir(dir_a), .moving(mov_a), .anim(anim_a)
    );

    slime_patrol #(
        .X_LEFT(10'd100), .X_RIGHT(10'd110), .Y_FLOOR(9'd300),
        .STEP_DIV(4), .STEP_PX(4'd3), .PAUSE_TICKS(8'd2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .respawn(respawn_b),
        .x_slim(x_b), .y_slim(y_b), .dir(dir_b), .moving(mov_b), .anim(anim_b)
    );

    function automatic exp_t mk(input int delta, input int x, input bit d, input bit m, input int a);
        exp_t e;
        e.delta = delta;
        e.val   = {10'(x), 9'd300, d, m, 2'(a)};
        return e;
    endfunction

    task automatic check_change(input string name, input bit have, input exp_t e,
                                input logic [22:0] cur, input int delta);
        vectors++;
        if (!have) begin
            miscompares++;
            $display("FAIL %s unexpected change at cycle %0d: x=%0d dir=%0d mov=%0d anim=%0d",
                     name, cyc, cur[22:13], cur[3], cur[2], cur[1:0]);
        end else begin
            if (cur !== e.val || delta != e.delta) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got x=%0d y=%0d dir=%0d mov=%0d anim=%0d after %0d cycles, want x=%0d y=%0d dir=%0d mov=%0d anim=%0d after %0d cycles",
                         name, cyc, cur[22:13], cur[12:4], cur[3], cur[2], cur[1:0], delta,
                         e.val[22:13], e.val[12:4], e.val[3], e.val[2], e.val[1:0], e.delta);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] cur;
        exp_t e;
        bit have;
        cur = {x_a, y_a, dir_a, mov_a, anim_a};
        if (cur !== prev_a) begin
            have = (q_a.size() > 0);
            if (have) e = q_a.pop_front();
            check_change("A", have, e, cur, cyc - last_a);
            last_a = cyc;
            prev_a = cur;
        end
        cur = {x_b, y_b, dir_b, mov_b, anim_b};
        if (cur !== prev_b) begin
            have = (q_b.size() > 0);
            if (have) e = q_b.pop_front();
            check_change("B", have, e, cur, cyc - last_b);
            last_b = cyc;
            prev_b = cur;
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; enable_a = 1'b0; respawn_a = 1'b0; enable_b = 1'b0; respawn_b = 1'b0;

        // A: reset, idle, walk right with clamp, pause, walk left, pause, walk right
        q_a.push_back(mk(1,  100, 1, 0, 0));
        q_a.push_back(mk(13, 100, 1, 1, 0));
        q_a.push_back(mk(3,  102, 1, 1, 1));
        q_a.push_back(mk(4,  104, 1, 1, 2));
        q_a.push_back(mk(4,  106, 1, 1, 3));
        q_a.push_back(mk(4,  108, 1, 1, 0));
        q_a.push_back(mk(4,  110, 1, 0, 1));
        q_a.push_back(mk(8,  110, 0, 1, 1));
        q_a.push_back(mk(4,  108, 0, 1, 2));
        q_a.push_back(mk(4,  106, 0, 1, 3));
        q_a.push_back(mk(4,  104, 0, 1, 0));
        q_a.push_back(mk(4,  102, 0, 1, 1));
        q_a.push_back(mk(4,  100, 0, 0, 2));
        q_a.push_back(mk(8,  100, 1, 1, 2));
        q_a.push_back(mk(4,  102, 1, 1, 3));
        q_a.push_back(mk(4,  104, 1, 1, 0));
        // enable low for 20 cycles with tick_cnt=2: step lands 2 cycles after resume
        q_a.push_back(mk(24, 106, 1, 1, 1));
        q_a.push_back(mk(4,  108, 1, 1, 2));
        q_a.push_back(mk(4,  110, 1, 0, 3));
        // respawn on the tick cycle in PAUSE_R
        q_a.push_back(mk(4,  100, 1, 1, 0));
        q_a.push_back(mk(4,  102, 1, 1, 1));
        // reset together with respawn lands in IDLE, then WALK_R one edge later
        q_a.push_back(mk(2,  100, 1, 0, 0));
        q_a.push_back(mk(1,  100, 1, 1, 0));

        // B: STEP_PX=3 clamps to 110 and 100
        q_b.push_back(mk(1,  100, 1, 0, 0));
        q_b.push_back(mk(13, 100, 1, 1, 0));
        q_b.push_back(mk(3,  103, 1, 1, 1));
        q_b.push_back(mk(4,  106, 1, 1, 2));
        q_b.push_back(mk(4,  109, 1, 1, 3));
        q_b.push_back(mk(4,  110, 1, 0, 0));
        q_b.push_back(mk(8,  110, 0, 1, 0));
        q_b.push_back(mk(4,  107, 0, 1, 1));
        q_b.push_back(mk(4,  104, 0, 1, 2));
        q_b.push_back(mk(4,  101, 0, 1, 3));
        q_b.push_back(mk(4,  100, 0, 0, 0));
        q_b.push_back(mk(8,  100, 1, 1, 0));
        q_b.push_back(mk(58, 100, 1, 0, 0));

        wait_to(3);   rst_n = 1'b1;
        wait_to(13);  enable_a = 1'b1; enable_b = 1'b1;
        wait_to(61);  enable_b = 1'b0;
        wait_to(79);  enable_a = 1'b0;
        wait_to(99);  enable_a = 1'b1;
        wait_to(112); respawn_a = 1'b1;
        wait_to(113); respawn_a = 1'b0;
        wait_to(118); rst_n = 1'b0; respawn_a = 1'b1;
        wait_to(119); rst_n = 1'b1; respawn_a = 1'b0;
        wait_to(120); enable_a = 1'b0;
        wait_to(130);

        vectors++;
        if (q_a.size() != 0) begin
            miscompares++;
            $display("FAIL A pending: %0d expected changes never seen, want 0", q_a.size());
        end
        vectors++;
        if (q_b.size() != 0) begin
            miscompares++;
            $display("FAIL B pending: %0d expected changes never seen, want 0", q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
